// File: rtl/cyq_74hc595_pkg.sv
// cyq_sipo_pkg: shared types and constants for the cyq_74hc595 serial-in,
// parallel-out receiver.
//   cnt_state_t : bit-counter states (IDLE, SHIFT, FULL)
//   DEFAULT_W   : default word width
//   cnt_width() : width of the CNT output for a given word width
package cyq_sipo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } cnt_state_t;

    localparam int DEFAULT_W = 8;

    // CNT has to hold the value W itself, so it needs one bit more than clog2(W).
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/cyq_74hc595_if.sv
// cyq_74hc595_if: serial-link and parallel-output signal bundle of the
// cyq_74hc595 receiver.
//   Ds  : serial data in (from the 165's Y)
//   CE  : shift enable, active-low
//   ST  : store request, active-high
//   OE  : output enable, active-low
//   Q   : latched parallel word [0:W-1]
//   Q7S : cascade serial out
//   CNT : bits received since the last latch
//   VLD : one-cycle pulse after every latch update
// master drives the link inputs; slave is the receiver.
interface cyq_74hc595_if #(
    parameter int W = cyq_sipo_pkg::DEFAULT_W
);
    logic                                  Ds;
    logic                                  CE;
    logic                                  ST;
    logic                                  OE;
    logic [0:W-1]                          Q;
    logic                                  Q7S;
    logic [cyq_sipo_pkg::cnt_width(W)-1:0] CNT;
    logic                                  VLD;

    modport master (
        output Ds, CE, ST, OE,
        input  Q, Q7S, CNT, VLD
    );

    modport slave (
        input  Ds, CE, ST, OE,
        output Q, Q7S, CNT, VLD
    );
endinterface

// File: rtl/cyq_74hc595_bit_counter.sv
// cyq_bit_counter: saturating count of bits received since the last latch.
// Ports:
//   CP, MR   : clock (rising edge), asynchronous active-high reset
//   i_shift  : a bit is shifted in at this edge
//   i_latch  : store request (ST) at this edge
//   o_cnt    : bits received since the last latch, saturating at W
//   o_state  : counter state
//   o_full   : counter holds W bits
//   o_auto   : this edge shifts in the W-th bit and AUTO_LATCH is set;
//              the parent latches the word on this pulse
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no bits since the last latch, CNT = 0
// SHIFT | partial word, 1 <= CNT <= W-1
// FULL  | W or more bits since the last latch, CNT = W
module cyq_bit_counter
    import cyq_sipo_pkg::*;
#(
    parameter int W          = DEFAULT_W,
    parameter bit AUTO_LATCH = 1'b0
) (
    input  logic                    CP,
    input  logic                    MR,
    input  logic                    i_shift,
    input  logic                    i_latch,
    output logic [cnt_width(W)-1:0] o_cnt,
    output cnt_state_t              o_state,
    output logic                    o_full,
    output logic                    o_auto
);
    localparam int CW = cnt_width(W);

    cnt_state_t      r_state;
    cnt_state_t      w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            w_fill;

    assign w_fill = i_shift && (r_state == SHIFT) && (r_cnt == CW'(W - 1));
    assign o_auto = AUTO_LATCH && w_fill;

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (o_auto) begin
            // The auto-latch already contains the W-th bit, so nothing is pending.
            w_state_next = IDLE;
            w_cnt_next   = '0;
        end else if (i_latch) begin
            // A bit shifted on the latch edge is not in the stored word.
            w_state_next = i_shift ? SHIFT : IDLE;
            w_cnt_next   = i_shift ? CW'(1) : '0;
        end else if (i_shift) begin
            case (r_state)
                IDLE: begin
                    w_state_next = SHIFT;
                    w_cnt_next   = CW'(1);
                end
                SHIFT: begin
                    if (w_fill) begin
                        w_state_next = FULL;
                        w_cnt_next   = CW'(W);
                    end else begin
                        w_state_next = SHIFT;
                        w_cnt_next   = r_cnt + CW'(1);
                    end
                end
                FULL: begin
                    w_state_next = FULL;
                    w_cnt_next   = CW'(W);
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    assign o_cnt   = r_cnt;
    assign o_state = r_state;
    assign o_full  = (r_state == FULL);

endmodule

// File: rtl/cyq_74hc595.sv
// cyq_74hc595: serial-in, parallel-out shift register with output latch.
// Receives the 74HC165-style serial stream and rebuilds the parallel word.
// Ports:
//   CP  : clock, rising edge
//   MR  : asynchronous active-high reset
//   bus : cyq_74hc595_if.slave (Ds, CE, ST, OE in; Q, Q7S, CNT, VLD out)
// Build option:
//   CYQ_74HC595_AUTO_LATCH_EN defined   -> the edge that shifts in the W-th
//                                          bit also latches the word.
//   CYQ_74HC595_AUTO_LATCH_EN undefined -> the latch updates only on ST.
module cyq_74hc595
    import cyq_sipo_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input logic          CP,
    input logic          MR,
    cyq_74hc595_if.slave bus
);
    localparam int CW = cnt_width(W);

`ifdef CYQ_74HC595_AUTO_LATCH_EN
    localparam bit AUTO_LATCH = 1'b1;
`else
    localparam bit AUTO_LATCH = 1'b0;
`endif

    logic [0:W-1]  r_s;
    logic [0:W-1]  r_l;
    logic          r_vld;
    logic [0:W-1]  w_s_next;
    logic          w_shift;
    logic          w_auto;
    logic          w_full;
    logic [CW-1:0] w_cnt;
    cnt_state_t    w_state;

    assign w_shift  = ~bus.CE;
    // The newest bit enters S[0]; the first bit received ends up in S[W-1].
    assign w_s_next = w_shift ? {bus.Ds, r_s[0:W-2]} : r_s;

    cyq_bit_counter #(
        .W          (W),
        .AUTO_LATCH (AUTO_LATCH)
    ) u_bit_counter (
        .CP      (CP),
        .MR      (MR),
        .i_shift (w_shift),
        .i_latch (bus.ST),
        .o_cnt   (w_cnt),
        .o_state (w_state),
        .o_full  (w_full),
        .o_auto  (w_auto)
    );

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            r_s   <= '0;
            r_l   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_s <= w_s_next;
            // Auto-latch takes priority over ST: it includes the bit shifted now.
            if (w_auto) begin
                r_l <= w_s_next;
            end else if (bus.ST) begin
                r_l <= r_s;
            end
            r_vld <= w_auto | bus.ST;
        end
    end

    assign bus.Q   = bus.OE ? '0 : r_l;
    assign bus.Q7S = r_s[W-1];
    assign bus.CNT = w_cnt;
    assign bus.VLD = r_vld;

    a_full_cnt : assert property (@(posedge CP) disable iff (MR)
        w_full == (w_cnt == CW'(W)));
    a_idle_cnt : assert property (@(posedge CP) disable iff (MR)
        (w_state == IDLE) == (w_cnt == '0));

endmodule
